// File: rtl/mult_div_unit.sv
`default_nettype none
// =============================================================================
// Module : mult_div_unit
// Iterative MULT/MULTU/DIV/DIVU (WIDTH+1 cycles) with HI/LO and 1-cycle MTHI/MTLO.
// Revision: 1.0
// =============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int         CNT_W   = $clog2(WIDTH);
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     ina_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dz_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 signed_op;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_r;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Multiply keeps the multiplier in the low half and shifts the product in from the top;
  // divide keeps remainder:dividend and shifts quotient bits into the low end.
  always_comb begin
    signed_op = ~op[0];
    mag_a     = (signed_op && ina[WIDTH-1]) ? -ina : ina;
    mag_b     = (signed_op && inb[WIDTH-1]) ? -inb : inb;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    div_r     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_r[WIDTH-1:0] - b_q;
    div_ge    = (div_r >= {1'b0, b_q});
    if (is_div_q)
      acc_d = {(div_ge ? div_diff : div_r[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    else if (acc_q[0])
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    else
      acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      ina_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!op[2]) begin
              acc_q     <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
              b_q       <= op[1] ? mag_b : mag_a;
              ina_q     <= ina;
              is_div_q  <= op[1];
              neg_res_q <= signed_op & (ina[WIDTH-1] ^ inb[WIDTH-1]);
              neg_rem_q <= signed_op & ina[WIDTH-1];
              dz_q      <= op[1] & (inb == '0);
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= S_RUN;
            end else if (op == OP_MTHI) begin
              hi_q   <= ina;
              done_q <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo_q   <= ina;
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1))
              state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            done_q <= 1'b1;
            dbz_q  <= dz_q;
            if (!is_div_q) begin
              {hi_q, lo_q} <= prod_fix;
            end else if (dz_q) begin
              hi_q <= ina_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire
